// File: rtl/n_demux.sv
// n_demux: registered 1-to-5 demultiplexer for 16-bit words.
// One-entry buffer per destination; illegal selects are dropped and counted.
module n_demux (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [15:0] io_in_bits,
    input  logic [2:0]  io_in_sel,
    output logic [15:0] io_Ovect_0,
    output logic [15:0] io_Ovect_1,
    output logic [15:0] io_Ovect_2,
    output logic [15:0] io_Ovect_3,
    output logic [15:0] io_Ovect_4,
    output logic        io_Ovect_0_valid,
    output logic        io_Ovect_1_valid,
    output logic        io_Ovect_2_valid,
    output logic        io_Ovect_3_valid,
    output logic        io_Ovect_4_valid,
    input  logic        io_Ovect_0_ready,
    input  logic        io_Ovect_1_ready,
    input  logic        io_Ovect_2_ready,
    input  logic        io_Ovect_3_ready,
    input  logic        io_Ovect_4_ready,
    output logic [7:0]  io_drop_cnt,
    output logic        io_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e  state_q [5];
    buf_state_e  state_d [5];
    logic [15:0] data_q  [5];
    logic [15:0] data_d  [5];
    logic [4:0]  oready;
    logic [4:0]  acc;
    logic        legal;
    logic        drop;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        err_q;
    logic        err_d;

    assign oready = {io_Ovect_4_ready, io_Ovect_3_ready,
                     io_Ovect_2_ready, io_Ovect_1_ready,
                     io_Ovect_0_ready};

    // Input ready and per-destination accept strobes; illegal selects always drain.
    always_comb begin
        io_in_ready = 1'b1;
        legal       = 1'b0;
        acc         = '0;
        for (int k = 0; k < 5; k++) begin
            if (io_in_sel == 3'(k)) begin
                legal       = 1'b1;
                io_in_ready = (state_q[k] == EMPTY) || oready[k];
            end
        end
        for (int k = 0; k < 5; k++) begin
            acc[k] = io_in_valid && io_in_ready && (io_in_sel == 3'(k));
        end
        drop = io_in_valid && !legal;
    end

    // Per-buffer EMPTY/FULL next state; an accept while FULL refills in place.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            case (state_q[k])
                EMPTY: begin
                    if (acc[k]) begin
                        state_d[k] = FULL;
                        data_d[k]  = io_in_bits;
                    end
                end
                FULL: begin
                    if (acc[k]) begin
                        data_d[k] = io_in_bits;
                    end else if (oready[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    // Saturating drop counter and sticky error flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (drop) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset empties every buffer without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 5; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= 16'h0000;
            end
            cnt_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign io_Ovect_0 = data_q[0];
    assign io_Ovect_1 = data_q[1];
    assign io_Ovect_2 = data_q[2];
    assign io_Ovect_3 = data_q[3];
    assign io_Ovect_4 = data_q[4];

    assign io_Ovect_0_valid = (state_q[0] == FULL);
    assign io_Ovect_1_valid = (state_q[1] == FULL);
    assign io_Ovect_2_valid = (state_q[2] == FULL);
    assign io_Ovect_3_valid = (state_q[3] == FULL);
    assign io_Ovect_4_valid = (state_q[4] == FULL);

    assign io_drop_cnt = cnt_q;
    assign io_err      = err_q;

endmodule

// File: tb/tb_n_demux.sv
// tb_n_demux: scoreboard bench for n_demux.
// Per-destination expected-word queues, a drop tally and a ready predictor.
module tb_n_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_bits;
    logic [2:0]  io_in_sel;
    logic [15:0] od   [5];
    logic        ov   [5];
    logic        ordy [5];
    logic [7:0]  io_drop_cnt;
    logic        io_err;

    logic [15:0] exp_q [5][$];
    int          drops;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    n_demux dut (
        .clk              (clk),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_ready      (io_in_ready),
        .io_in_bits       (io_in_bits),
        .io_in_sel        (io_in_sel),
        .io_Ovect_0       (od[0]),
        .io_Ovect_1       (od[1]),
        .io_Ovect_2       (od[2]),
        .io_Ovect_3       (od[3]),
        .io_Ovect_4       (od[4]),
        .io_Ovect_0_valid (ov[0]),
        .io_Ovect_1_valid (ov[1]),
        .io_Ovect_2_valid (ov[2]),
        .io_Ovect_3_valid (ov[3]),
        .io_Ovect_4_valid (ov[4]),
        .io_Ovect_0_ready (ordy[0]),
        .io_Ovect_1_ready (ordy[1]),
        .io_Ovect_2_ready (ordy[2]),
        .io_Ovect_3_ready (ordy[3]),
        .io_Ovect_4_ready (ordy[4]),
        .io_drop_cnt      (io_drop_cnt),
        .io_err           (io_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [15:0] b, input logic [4:0] r);
        @(posedge clk);
        #1;
        io_in_valid = v;
        io_in_sel   = s;
        io_in_bits  = b;
        for (int k = 0; k < 5; k++) ordy[k] = r[k];
    endtask

    task automatic clear_model();
        for (int k = 0; k < 5; k++) exp_q[k].delete();
        drops = 0;
    endtask

    // Monitor: compare outputs against the scoreboard, retire consumed words.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            check($sformatf("valid%0d", k), 32'(ov[k]),
                  32'(exp_q[k].size() != 0));
            if (exp_q[k].size() != 0) begin
                check($sformatf("data%0d", k), 32'(od[k]),
                      32'(exp_q[k][0]));
                if (reset && ordy[k]) void'(exp_q[k].pop_front());
            end
        end
        check("drop_cnt", 32'(io_drop_cnt), (drops > 255) ? 255 : drops);
        check("err", 32'(io_err), 32'(drops != 0));
    end

    // Predictor: expected ready, then record what the next edge accepts.
    always @(negedge clk) begin
        logic exp_rdy;
        #2;
        if (io_in_sel > 3'd4) exp_rdy = 1'b1;
        else exp_rdy = (exp_q[io_in_sel].size() == 0);
        check("in_ready", 32'(io_in_ready), 32'(exp_rdy));
        if (reset && io_in_valid && exp_rdy) begin
            if (io_in_sel > 3'd4) drops++;
            else exp_q[io_in_sel].push_back(io_in_bits);
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        drops = 0;
        reset = 1'b0;
        io_in_valid = 1'b0;
        io_in_sel = 3'd0;
        io_in_bits = 16'h0;
        for (int k = 0; k < 5; k++) ordy[k] = 1'b0;
        #2;
        check("rst_ready", 32'(io_in_ready), 1);
        check("rst_cnt", 32'(io_drop_cnt), 0);
        check("rst_err", 32'(io_err), 0);
        for (int k = 0; k < 5; k++) begin
            check("rst_valid", 32'(ov[k]), 0);
            check("rst_data", 32'(od[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // basic routing
        drive(1, 3'd2, 16'h1234, 5'h00);
        drive(0, 3'd0, 16'h0000, 5'h00);
        @(negedge clk);
        check("basic_data2", 32'(od[2]), 32'h1234);
        drive(0, 3'd0, 16'h0000, 5'h1f);

        // backpressure and pass-through refill
        drive(1, 3'd3, 16'hAAAA, 5'h00);
        drive(1, 3'd3, 16'hBBBB, 5'h00);
        drive(1, 3'd3, 16'hBBBB, 5'h08);
        drive(0, 3'd0, 16'h0000, 5'h00);
        @(negedge clk);
        check("bp_data3", 32'(od[3]), 32'hBBBB);
        drive(0, 3'd0, 16'h0000, 5'h1f);

        // independence
        drive(1, 3'd0, 16'h00F0, 5'h00);
        drive(1, 3'd1, 16'h0001, 5'h00);
        drive(1, 3'd4, 16'h0004, 5'h00);
        drive(0, 3'd0, 16'h0000, 5'h00);
        @(negedge clk);
        check("ind_data0", 32'(od[0]), 32'h00F0);
        check("ind_data4", 32'(od[4]), 32'h0004);
        drive(0, 3'd0, 16'h0000, 5'h1f);

        // illegal selects
        drive(1, 3'd5, 16'h5555, 5'h00);
        drive(1, 3'd6, 16'h6666, 5'h00);
        drive(1, 3'd7, 16'h7777, 5'h00);
        drive(0, 3'd0, 16'h0000, 5'h00);
        @(negedge clk);
        check("illegal_cnt", 32'(io_drop_cnt), 3);
        check("illegal_err", 32'(io_err), 1);

        // asynchronous reset between edges
        drive(1, 3'd1, 16'h1111, 5'h00);
        drive(1, 3'd2, 16'h2222, 5'h00);
        drive(0, 3'd0, 16'h0000, 5'h00);
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        for (int k = 0; k < 5; k++) begin
            check("arst_valid", 32'(ov[k]), 0);
            check("arst_data", 32'(od[k]), 0);
        end
        check("arst_cnt", 32'(io_drop_cnt), 0);
        check("arst_err", 32'(io_err), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // randomized traffic
        repeat (1500) begin
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  16'($urandom), 5'($urandom));
        end
        drive(0, 3'd0, 16'h0000, 5'h1f);

        // saturation
        repeat (260) begin
            drive(1, 3'($urandom_range(5, 7)), 16'($urandom),
                  5'($urandom));
        end
        drive(0, 3'd0, 16'h0000, 5'h1f);
        @(negedge clk);
        check("sat_cnt", 32'(io_drop_cnt), 255);
        check("sat_err", 32'(io_err), 1);

        repeat (3) drive(0, 3'd0, 16'h0000, 5'h1f);
        @(negedge clk);
        #3;
        for (int k = 0; k < 5; k++) begin
            check("drained", 32'(exp_q[k].size()), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/n_demux.md
# n_demux

Registered 1-to-5 demultiplexer for 16-bit words; the distribution-side counterpart of the team's 5-input selector `nMux`. A single producer stream carries a word plus a 3-bit destination select. The word is routed into one of five one-entry output buffers, each with its own valid/ready handshake. Illegal selects are consumed and counted rather than stalling the producer. It sits between a shared datapath source and five independent consumers.

## Interface
Parameters: none. Data width is fixed at 16 and there are five destinations.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronous to `clk`.
- `io_in_valid`  in  1  — producer offers a word.
- `io_in_ready`  out  1  — block accepts the word this cycle.
- `io_in_bits`  in  16  — data word.
- `io_in_sel`  in  3  — destination index. Values 0–4 are legal; 5–7 are illegal.
- `io_Ovect_k` (k = 0..4)  out  16  — buffered word for destination k.
- `io_Ovect_k_valid` (k = 0..4)  out  1  — buffer k holds a word.
- `io_Ovect_k_ready` (k = 0..4)  in  1  — consumer k takes the word this cycle.
- `io_drop_cnt`  out  8  — count of words dropped because of an illegal select. Saturates at 255.
- `io_err`  out  1  — sticky flag, set on the first illegal select.

## Operation
- **Accept condition.** A word is accepted when `io_in_valid && io_in_ready` is true at a rising edge.
- **Ready for a legal select (s ≤ 4).** `io_in_ready = !full_s || io_Ovect_s_ready`.
  - This is a combinational path from `io_Ovect_s_ready` to `io_in_ready`. It is permitted.
  - `io_in_ready` does not depend on `io_in_valid`.
- **Ready for an illegal select (s ≥ 5).** `io_in_ready = 1`.
  - The word is consumed and discarded.
  - `io_drop_cnt` increments, saturating at 255.
  - `io_err` sets and stays set until reset.
- **Per-buffer k states.**
  - EMPTY, on accept to k → FULL; register is loaded with `io_in_bits`.
  - FULL, on `io_Ovect_k_ready` with no accept to k → EMPTY.
  - FULL, on `io_Ovect_k_ready` and an accept to k in the same cycle → stays FULL; register is overwritten with the new word (pass-through refill).
  - FULL, with no `io_Ovect_k_ready` → holds. `io_in_ready` is 0 while `io_in_sel == k`.
- **Data stability.** `io_Ovect_k` is the registered word and is stable while `io_Ovect_k_valid` is 1 and the word has not been consumed.
- **Buffer independence.** Buffers are independent. A stalled destination blocks only words addressed to it; the producer changes `io_in_sel` to reach the others.
- **Ready ignored when empty.** `io_Ovect_k_ready` while `io_Ovect_k_valid` is 0 has no effect.
- **Invalid input is inert.** Input bits and select are ignored when `io_in_valid` is 0. `io_drop_cnt` and `io_err` change only on an accepted illegal select.

## Timing
- **Reset values.** All `io_Ovect_k` = 0x0000, all `io_Ovect_k_valid` = 0, `io_drop_cnt` = 0, `io_err` = 0.
- **Reset ready value.** `io_in_ready` during reset follows the combinational rule, which yields 1 because all buffers are empty. Accepts are ignored while reset is asserted.
- **Latency.** A word accepted at edge N is visible on `io_Ovect_s` with valid = 1 immediately after edge N, i.e. one-cycle latency.
- **Throughput.** One word per cycle into a single destination, provided that destination's consumer holds ready = 1 continuously.
- **Reset mid-operation.** All buffered words are lost. Valids drop asynchronously, without waiting for a clock edge. Counter and flag clear.
- **Counter saturation.** With `io_drop_cnt` at 255, further illegal selects leave it at 255 and keep `io_err` at 1.

## Test plan
- **Basic routing.** After reset, send 0x1234 with sel=2 in one cycle. Expect `io_Ovect_2` = 0x1234 with valid = 1 next cycle, all other valids 0, `io_drop_cnt` = 0.
- **Backpressure.** Fill buffer 3 with 0xAAAA while `io_Ovect_3_ready` = 0. Then present 0xBBBB with sel=3: expect `io_in_ready` = 0 and buffer still 0xAAAA. Raise ready: expect 0xBBBB accepted that cycle and shown next cycle, with valid continuously 1.
- **Independence.** With buffer 0 full and stalled, send 0x0001 with sel=1 and 0x0004 with sel=4 on consecutive cycles. Expect both accepted; `io_Ovect_1` = 0x0001, `io_Ovect_4` = 0x0004; buffer 0 unchanged.
- **Illegal select.** Send sel=5, 6, 7 in three cycles. Expect `io_in_ready` = 1 each cycle, no valid changes, `io_drop_cnt` = 3, `io_err` = 1.
- **Saturation.** Send 260 illegal selects. Expect `io_drop_cnt` = 255 and `io_err` = 1.
- **Async reset.** With buffers 1 and 2 full, assert `reset` low between clock edges. Expect all valids 0 and all data 0x0000 before the next edge, and the counter at 0.
